// File: rtl/manchester_pkg.sv
// manchester_pkg: shared state encoding and default widths for the Manchester TX chain.
package manchester_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/manchester_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first request searching upward from ptr_i+1 with wrap.
module rr_pick #(
    parameter int NUM_SRC = 2,
    parameter int IW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_SRC-1:0] onehot_o,
    output logic [IW-1:0]      idx_o,
    output logic               found_o
);

    logic [NUM_SRC-1:0] rot;
    logic [IW-1:0]      off;
    logic [IW:0]        sum;
    logic               hit;

    // Rotate so bit 0 is the slot after the pointer, take the lowest hit, then map back to an index.
    always_comb begin
        rot = NUM_SRC'({req_i, req_i} >> (ptr_i + IW'(1)));
        hit = 1'b0;
        off = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!hit && rot[k]) begin
                hit = 1'b1;
                off = IW'(k);
            end
        end
        sum      = {1'b0, ptr_i} + (IW+1)'(1) + {1'b0, off};
        idx_o    = (sum >= (IW+1)'(NUM_SRC)) ? IW'(sum - (IW+1)'(NUM_SRC)) : IW'(sum);
        found_o  = hit;
        onehot_o = hit ? (NUM_SRC'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/manchester_tx_arbiter.sv
// manchester_tx_arbiter: frame-atomic round-robin sharing of one Manchester TX chain, with a post-frame idle gap.
// Build option: define MANCHESTER_ARB_PRIO0_EN to make source 0 strict priority over the round-robin group.
module manchester_tx_arbiter
    import manchester_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int GAP_CYCLES = 16
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic [NUM_SRC-1:0]            grant,
    output logic                          busy
);

    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    arb_state_e            state_q;
    logic [NUM_SRC-1:0]    grant_q;
    logic [IW-1:0]         ptr_q;
    logic [IW-1:0]         own_q;
    logic [GW-1:0]         gap_q;
    logic [NUM_SRC-1:0]    rr_req;
    logic [NUM_SRC-1:0]    pick_onehot;
    logic [IW-1:0]         pick_idx;
    logic                  pick_found;
    logic                  prio0;
    logic                  xfer;
    logic                  eof;
    logic [DATA_WIDTH-1:0] src_data [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign src_data[g] = s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

`ifdef MANCHESTER_ARB_PRIO0_EN
    assign prio0  = s_axis_tvalid[0];
    assign rr_req = s_axis_tvalid & ~NUM_SRC'(1);
`else
    assign prio0  = 1'b0;
    assign rr_req = s_axis_tvalid;
`endif

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IW      (IW)
    ) u_pick (
        .req_i    (rr_req),
        .ptr_i    (ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .found_o  (pick_found)
    );

    assign xfer          = state_q == ST_XFER;
    assign m_axis_tdata  = xfer ? src_data[own_q] : '0;
    assign m_axis_tvalid = xfer & s_axis_tvalid[own_q];
    assign m_axis_tlast  = xfer & s_axis_tlast[own_q];
    assign s_axis_tready = xfer ? (grant_q & {NUM_SRC{m_axis_tready}}) : '0;
    assign eof           = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    assign grant         = grant_q;
    assign busy          = state_q != ST_IDLE;

    // Arbitrate in IDLE, hold the owner until its tlast handshake, then count out the idle gap.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= IW'(NUM_SRC - 1);
            own_q   <= '0;
            gap_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (prio0) begin
                        grant_q <= NUM_SRC'(1);
                        own_q   <= '0;
                        state_q <= ST_XFER;
                    end else if (pick_found) begin
                        grant_q <= pick_onehot;
                        own_q   <= pick_idx;
                        ptr_q   <= pick_idx;
                        state_q <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (eof) begin
                        grant_q <= '0;
                        if (GAP_CYCLES == 0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            gap_q   <= GW'(GAP_CYCLES);
                            state_q <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    gap_q <= gap_q - GW'(1);
                    if (gap_q == GW'(1)) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/manchester_tx_arbiter.md
Name: manchester_tx_arbiter

Overview:
- Shares one Manchester transmit chain (framer output → escaper → preamble → serializer) between NUM_SRC independent AXI-Stream frame sources.
- Arbitration is frame-atomic round-robin: a granted source keeps the chain until its tlast beat is accepted.
- After each frame, a programmable idle gap is inserted so the preamble/decoder sees clean frame separation.
- Sits between the per-source framers and the single manchester_escape instance.

Parameters:
- NUM_SRC, 2, number of requesting sources (2..8).
- DATA_WIDTH, 8, AXI-Stream tdata width per source.
- GAP_CYCLES, 16, idle cycles after a frame's tlast handshake before the next arbitration (0 allowed).

Ports:
- aclk  in  1  single clock.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  NUM_SRC*DATA_WIDTH  source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tlast  in  NUM_SRC  per-source end of frame.
- s_axis_tready  out  NUM_SRC  per-source ready.
- m_axis_tdata  out  DATA_WIDTH  to escaper.
- m_axis_tvalid  out  1  to escaper.
- m_axis_tlast  out  1  to escaper.
- m_axis_tready  in  1  from escaper.
- grant  out  NUM_SRC  one-hot index of the current owner; 0 when none.
- busy  out  1  high in XFER or GAP.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; grant=0, busy=0, gap counter=0.
  - Last-grant pointer=NUM_SRC-1, so source 0 has highest priority first.
  - All s_axis_tready=0; m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
- FSM states: IDLE, XFER, GAP.
- IDLE:
  - m_axis_tvalid=0; all s_axis_tready=0.
  - If any s_axis_tvalid is high, pick the first valid index searching upward from pointer+1, wrapping modulo NUM_SRC.
  - Register grant (one-hot) and pointer=winner, then go to XFER.
  - Arbitration latency: 1 cycle from tvalid to grant.
- XFER (zero-latency combinational passthrough of the owner g):
  - m_axis_tdata/tvalid/tlast = source g.
  - s_axis_tready[g]=m_axis_tready; all other readys are 0.
  - Non-owner tvalid is ignored; there is no preemption.
  - Owner tvalid low mid-frame: m_axis_tvalid=0 and the grant is held indefinitely.
- End of frame:
  - On a handshake (m_axis_tvalid & m_axis_tready & m_axis_tlast), clear grant.
  - If GAP_CYCLES==0, go directly to IDLE.
  - Otherwise load counter=GAP_CYCLES and go to GAP.
- GAP:
  - m_axis_tvalid=0; all readys 0; busy=1.
  - Decrement the counter each cycle; on counter==1, go to IDLE.
  - Exactly GAP_CYCLES idle cycles are observed on m_axis between the tlast beat and the IDLE cycle.
- Fairness:
  - With all sources continuously requesting, grants rotate 0,1,…,NUM_SRC-1,0.
  - A source that drops its request is skipped without a wasted cycle.
- Single-beat frame (tvalid & tlast on the first beat): a legal frame; goes to GAP after that beat.
- Reset mid-frame:
  - Immediately drops tvalid and the grant.
  - The partial frame is abandoned; the downstream chain is reset by the same aresetn.
- Outputs in IDLE/GAP are registered-state-derived; in XFER the tready/tvalid paths are combinational through the mux only.

Optional Feature:
- Macro MANCHESTER_ARB_PRIO0_EN.
- Defined: source 0 is strict-priority. In IDLE, if s_axis_tvalid[0]=1, source 0 wins regardless of the pointer, and the pointer is not updated by source-0 grants. Other sources arbitrate round-robin among themselves. Frames remain atomic; there is no preemption.
- Undefined: pure round-robin as above.

Decomposition:
- Shared package manchester_pkg: state encoding constants (ST_IDLE, ST_XFER, ST_GAP) and the default DATA_WIDTH, also usable by framer, escaper and decoder.
- One natural sub-module: rr_pick. Combinational; inputs are the request vector and pointer; outputs are the one-hot winner and its index. Parameterised by NUM_SRC; unit-testable alone.

Test Plan:
- Reset, then src0 sends a 3-beat frame 0x11,0x22,0x33(tlast) with m_axis_tready=1:
  - grant=01 one cycle after tvalid; m_axis carries 0x11,0x22,0x33, tlast on 0x33.
  - Then 16 idle cycles; busy=0 afterwards.
- src0 and src1 both request continuously with 2-beat frames:
  - Grant order 0,1,0,1.
  - s_axis_tready of the non-owner stays 0 throughout.
- Downstream backpressure (m_axis_tready toggling 1,0,0,1) during src1 frame 0xA0,0xA1(tlast):
  - No beat lost or duplicated; src1 tready mirrors m_axis_tready exactly.
- GAP_CYCLES=0, src1 sends a single-beat frame 0x5A with tlast:
  - Back-to-back re-arbitration; the next request is granted on the cycle after the IDLE cycle.
- aresetn asserted mid-frame after beat 2 of 4 from src0:
  - grant=0, m_axis_tvalid=0 immediately.
  - After release, src1 requesting alone is granted first without stale state.
- With MANCHESTER_ARB_PRIO0_EN defined, src0/src1/src2 all requesting:
  - src0 wins every arbitration; with src0 idle, src1 and src2 alternate.
